// File: rtl/ccff_bitstream_loader_if.sv
// Valid/ready word stream from the programming host into the configuration loader.
interface ccff_bitstream_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Serialises host words MSB-first into the configuration chain, then rotates the chain
// once and compares CRC-16-CCITT of the loaded bits against the bits seen at the tail.
module ccff_bitstream_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                   CK,
  input  logic                   RSTN,
  input  logic                   start,
  ccff_bitstream_loader_if.slave s,
  output logic                   ccff_head,
  output logic                   ccff_shift,
  input  logic                   ccff_tail,
  output logic                   busy,
  output logic                   done,
  output logic                   crc_ok
);
  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int WCNT_W = $clog2(NWORDS + 1);
  localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WCNT_W-1:0] NWORDS_C = WCNT_W'(NWORDS);
  localparam logic [IDX_W-1:0]  TOP_IDX  = IDX_W'(WORD_W - 1);
  localparam logic [15:0]       CRC_POLY = 16'h1021;
  localparam logic [15:0]       CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   bit_cnt_reg;
  logic [WCNT_W-1:0]  word_cnt_reg;
  logic [WORD_W-1:0]  buf_reg;
  logic               buf_valid_reg;
  logic [IDX_W-1:0]   bit_idx_reg;
  logic [15:0]        load_crc_reg;
  logic [15:0]        verify_crc_reg;

  logic buf_bit;
  logic last_in_word;
  logic last_chain_bit;
  logic accept;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

  assign buf_bit        = buf_reg[bit_idx_reg];
  assign last_in_word   = buf_valid_reg && (bit_idx_reg == '0);
  assign last_chain_bit = (bit_cnt_reg == LAST_BIT);
  assign accept         = s.s_ready && s.s_valid;

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (buf_valid_reg && last_chain_bit) state_next = VERIFY;
      VERIFY:  if (last_chain_bit) state_next = DONE;
      DONE:    if (start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s.s_ready  = 1'b0;
    ccff_head  = 1'b0;
    ccff_shift = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    crc_ok     = 1'b0;
    case (state_reg)
      LOAD: begin
        busy = 1'b1;
        // Refill on the last bit of the current word so a held s_valid gives no bubble.
        s.s_ready  = (!buf_valid_reg || last_in_word) && (word_cnt_reg < NWORDS_C);
        ccff_shift = buf_valid_reg;
        ccff_head  = buf_valid_reg & buf_bit;
      end
      VERIFY: begin
        busy       = 1'b1;
        ccff_shift = 1'b1;
        ccff_head  = ccff_tail;
      end
      DONE: begin
        done   = 1'b1;
        crc_ok = (load_crc_reg == verify_crc_reg);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      bit_cnt_reg    <= '0;
      word_cnt_reg   <= '0;
      buf_reg        <= '0;
      buf_valid_reg  <= 1'b0;
      bit_idx_reg    <= '0;
      load_crc_reg   <= '0;
      verify_crc_reg <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            bit_cnt_reg    <= '0;
            word_cnt_reg   <= '0;
            buf_valid_reg  <= 1'b0;
            bit_idx_reg    <= '0;
            load_crc_reg   <= CRC_INIT;
            verify_crc_reg <= CRC_INIT;
          end
        end
        LOAD: begin
          if (buf_valid_reg) begin
            load_crc_reg <= crc_step(load_crc_reg, buf_bit);
            bit_cnt_reg  <= bit_cnt_reg + 1'b1;
            if (last_in_word) begin
              buf_valid_reg <= 1'b0;
            end else begin
              bit_idx_reg <= bit_idx_reg - 1'b1;
            end
          end
          if (accept) begin
            buf_reg       <= s.s_data;
            buf_valid_reg <= 1'b1;
            bit_idx_reg   <= TOP_IDX;
            word_cnt_reg  <= word_cnt_reg + 1'b1;
          end
          // Chain full: drop whatever is left of the final word.
          if (buf_valid_reg && last_chain_bit) begin
            bit_cnt_reg   <= '0;
            buf_valid_reg <= 1'b0;
          end
        end
        VERIFY: begin
          verify_crc_reg <= crc_step(verify_crc_reg, ccff_tail);
          bit_cnt_reg    <= bit_cnt_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader with a 20-flop chain model on CK.
module tb_ccff_bitstream_loader;
  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 20;

  logic CK = 1'b0;
  logic RSTN = 1'b0;
  logic start = 1'b0;
  logic ccff_head, ccff_shift, ccff_tail, busy, done, crc_ok;
  logic [CHAIN_LEN-1:0] chain = '0;
  logic tail_stuck = 1'b0;
  int errors = 0;
  int checks = 0;

  logic [WORD_W-1:0] words [3];

  typedef struct {
    int             gap;
    bit             fault;
    bit             poke;
    int             exp_acc;
    int             exp_shifts;
    int             exp_busy;
    logic [19:0]    exp_load;
    logic [19:0]    exp_final;
    bit             exp_crc;
  } vec_t;

  vec_t vecs [4];

  ccff_bitstream_loader_if #(.WORD_W(WORD_W)) s_if ();

  ccff_bitstream_loader #(
    .WORD_W   (WORD_W),
    .CHAIN_LEN(CHAIN_LEN)
  ) dut (
    .CK        (CK),
    .RSTN      (RSTN),
    .start     (start),
    .s         (s_if),
    .ccff_head (ccff_head),
    .ccff_shift(ccff_shift),
    .ccff_tail (ccff_tail),
    .busy      (busy),
    .done      (done),
    .crc_ok    (crc_ok)
  );

  always #5 CK = ~CK;

  always @(posedge CK) begin
    if (ccff_shift) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
  end
  assign ccff_tail = tail_stuck ? 1'b0 : chain[CHAIN_LEN-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {s_if.s_ready, ccff_head, ccff_shift, busy, done, crc_ok};
  endfunction

  task automatic run_row(input int r, input vec_t v);
    int acc, shifts, busy_cnt, widx, gap_left;
    logic [CHAIN_LEN-1:0] load_img;
    bit snap, finished;
    acc = 0; shifts = 0; busy_cnt = 0; widx = 0; gap_left = 0;
    load_img = '0; snap = 0; finished = 0;
    tail_stuck = v.fault;
    @(negedge CK);
    start = 1'b1;
    s_if.s_valid = 1'b1;
    s_if.s_data  = words[0];
    #1 check($sformatf("r%0d ready_with_start", r), 32'(s_if.s_ready), 32'd0);
    @(negedge CK);
    start = 1'b0;
    #1 check($sformatf("r%0d enter_load", r), 32'({done, busy, s_if.s_ready}), 32'b011);
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      if (shifts == CHAIN_LEN && !snap) begin
        load_img = chain;
        snap = 1;
      end
      start = v.poke && (busy_cnt == 5 || shifts == 30);
      if (widx < 3 && gap_left == 0) begin
        s_if.s_valid = 1'b1;
        s_if.s_data  = words[widx];
      end else if (widx >= 3 && v.gap == 0) begin
        s_if.s_valid = 1'b1;
        s_if.s_data  = 8'hFF;
      end else begin
        s_if.s_valid = 1'b0;
      end
      #1;
      if (done) begin
        finished = 1;
      end else begin
        if (busy) busy_cnt++;
        if (ccff_shift) shifts++;
        if (s_if.s_valid && s_if.s_ready) begin
          acc++;
          widx++;
          gap_left = (widx < 3) ? v.gap : 0;
        end else if (!s_if.s_valid && s_if.s_ready && gap_left > 0) begin
          gap_left--;
        end
        @(negedge CK);
      end
    end
    start = 1'b0;
    s_if.s_valid = 1'b0;
    check($sformatf("r%0d done_reached", r), 32'(finished), 32'd1);
    check($sformatf("r%0d accepts", r), 32'(acc), 32'(v.exp_acc));
    check($sformatf("r%0d shifts", r), 32'(shifts), 32'(v.exp_shifts));
    check($sformatf("r%0d busy_cycles", r), 32'(busy_cnt), 32'(v.exp_busy));
    check($sformatf("r%0d load_image", r), 32'(load_img), 32'(v.exp_load));
    check($sformatf("r%0d final_image", r), 32'(chain), 32'(v.exp_final));
    check($sformatf("r%0d crc_ok", r), 32'(crc_ok), 32'(v.exp_crc));
    $display("row %0d gap=%0d fault=%0b poke=%0b acc=%0d shifts=%0d busy=%0d chain=%05h crc_ok=%0b",
             r, v.gap, v.fault, v.poke, acc, shifts, busy_cnt, chain, crc_ok);
    tail_stuck = 1'b0;
  endtask

  task automatic reset_mid_load();
    int shifts, widx;
    bit reached;
    shifts = 0; widx = 0; reached = 0;
    @(negedge CK);
    start = 1'b1;
    s_if.s_valid = 1'b1;
    s_if.s_data  = words[0];
    @(negedge CK);
    start = 1'b0;
    for (int cyc = 0; cyc < 100 && !reached; cyc++) begin
      s_if.s_valid = 1'b1;
      s_if.s_data  = words[(widx < 3) ? widx : 0];
      #1;
      if (ccff_shift) shifts++;
      if (s_if.s_valid && s_if.s_ready) widx++;
      @(negedge CK);
      if (shifts == 10) reached = 1;
    end
    check("mid_load_reached", 32'(reached), 32'd1);
    #2;
    check("busy_before_reset", 32'(busy), 32'd1);
    RSTN = 1'b0;
    #1 check("outs_async_reset_load", 32'(outs()), 32'd0);
    s_if.s_valid = 1'b0;
    @(negedge CK);
    @(negedge CK);
    RSTN = 1'b1;
    #1 check("outs_after_release", 32'(outs()), 32'd0);
    $display("reset mid-load after %0d shifts, %0d words", shifts, widx);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    words[2] = 8'hF0;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;

    //            gap fault poke acc shifts busy load      final     crc
    vecs[0] = '{0, 1'b0, 1'b0, 3, 40, 41, 20'hA53CF, 20'hA53CF, 1'b1};
    vecs[1] = '{3, 1'b0, 1'b0, 3, 40, 47, 20'hA53CF, 20'hA53CF, 1'b1};
    vecs[2] = '{0, 1'b1, 1'b0, 3, 40, 41, 20'hA53CF, 20'h00000, 1'b0};
    vecs[3] = '{0, 1'b0, 1'b1, 3, 40, 41, 20'hA53CF, 20'hA53CF, 1'b1};

    #1 check("outs_in_reset", 32'(outs()), 32'd0);
    @(negedge CK);
    @(negedge CK);
    RSTN = 1'b1;
    #1 check("outs_idle", 32'(outs()), 32'd0);
    $display("reset released");

    for (int i = 0; i < 4; i++) run_row(i, vecs[i]);

    #3;
    check("done_before_reset", 32'(done), 32'd1);
    RSTN = 1'b0;
    #1 check("outs_async_reset_done", 32'(outs()), 32'd0);
    @(negedge CK);
    RSTN = 1'b1;
    $display("reset from DONE");

    reset_mid_load();
    run_row(4, vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
